iir_coeff_loader: RTL

//  Upstream stage of iir_filter: accepts a serial stream of five coefficient words (b0,b1,b2,a1,a2)

---
 rtl/iir_pkg.sv | 29 ++
 rtl/iir_coeff_loader_if.sv | 12 +
 rtl/iir_coeff_csum.sv | 35 +++
 rtl/iir_coeff_loader.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Shared constants for the IIR coefficient path: word width, Q-format, coefficient slot order,
// loader state encodings and pass-through reset values.
package iir_pkg;

  localparam int COEF_WIDTH = 16;
  localparam int FRAC_BITS  = 14;
  localparam int NUM_COEF   = 5;

  localparam int IDX_B0   = 0;
  localparam int IDX_B1   = 1;
  localparam int IDX_B2   = 2;
  localparam int IDX_A1   = 3;
  localparam int IDX_A2   = 4;
  localparam int IDX_CSUM = 5;

  // 1.0 in Q2.14 on b0 with every other tap zero makes the filter a wire.
  localparam int B0_INIT_DEF = 1 << FRAC_BITS;
  localparam int B1_INIT_DEF = 0;
  localparam int B2_INIT_DEF = 0;
  localparam int A1_INIT_DEF = 0;
  localparam int A2_INIT_DEF = 0;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_PEND  = 2'd1,
    ST_CHECK = 2'd2
  } ld_state_e;

endpackage

// File: rtl/iir_coeff_loader_if.sv
// Coefficient configuration port: valid/ready word transfer plus an out-of-band abort.
interface iir_coeff_loader_if #(
  parameter int WIDTH = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_data;
  logic             cfg_abort;

  modport master (output cfg_valid, output cfg_data, output cfg_abort, input  cfg_ready);
  modport slave  (input  cfg_valid, input  cfg_data, input  cfg_abort, output cfg_ready);
endinterface

// File: rtl/iir_coeff_csum.sv
// Running XOR over every accepted word of a set; the set is good when data plus checksum XOR to zero.
// Result is visible the cycle after the last word is accumulated; no backpressure of its own.
module iir_coeff_csum #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             acc_en,
  input  logic [WIDTH-1:0] din,
  output logic             match
);

  logic [WIDTH-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (acc_en) begin
      acc_d = acc_q ^ din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign match = (acc_q == '0);

endmodule

// File: rtl/iir_coeff_loader.sv
// Shadow-banks five coefficient words and applies them atomically on sample_tick (new values and coeff_update appear
// the cycle after the tick edge); cfg_ready drops while a set is pending. COEFF_CHECKSUM_EN adds a sixth XOR word + check.
module iir_coeff_loader
  import iir_pkg::*;
#(
  parameter int WIDTH   = COEF_WIDTH,
  parameter int B0_INIT = B0_INIT_DEF,
  parameter int B1_INIT = B1_INIT_DEF,
  parameter int B2_INIT = B2_INIT_DEF,
  parameter int A1_INIT = A1_INIT_DEF,
  parameter int A2_INIT = A2_INIT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  iir_coeff_loader_if.slave       cfg,
  input  logic                    sample_tick,
  output logic signed [WIDTH-1:0] b0_out,
  output logic signed [WIDTH-1:0] b1_out,
  output logic signed [WIDTH-1:0] b2_out,
  output logic signed [WIDTH-1:0] a1_out,
  output logic signed [WIDTH-1:0] a2_out,
  output logic                    coeff_update,
  output logic                    pending,
  output logic                    load_err
);

  localparam logic [WIDTH-1:0] INIT_VAL [NUM_COEF] = '{
    WIDTH'(B0_INIT), WIDTH'(B1_INIT), WIDTH'(B2_INIT), WIDTH'(A1_INIT), WIDTH'(A2_INIT)
  };

  ld_state_e        state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [WIDTH-1:0] shadow_q [NUM_COEF];
  logic [WIDTH-1:0] shadow_d [NUM_COEF];
  logic [WIDTH-1:0] coef_q   [NUM_COEF];
  logic [WIDTH-1:0] coef_d   [NUM_COEF];
  logic             coeff_update_q, coeff_update_d;
  logic             accept;

  // An abort cycle drops whatever word is on the bus even though ready is high.
  assign cfg.cfg_ready = (state_q == ST_LOAD);
  assign accept        = cfg.cfg_valid & cfg.cfg_ready & ~cfg.cfg_abort;

`ifdef COEFF_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'(IDX_CSUM);
  logic csum_clr, csum_match;
  logic load_err_q, load_err_d;

  assign csum_clr = cfg.cfg_abort | (state_q == ST_CHECK);

  iir_coeff_csum #(.WIDTH(WIDTH)) u_csum (
    .clk    (clk),
    .rst    (rst),
    .clr    (csum_clr),
    .acc_en (accept),
    .din    (cfg.cfg_data),
    .match  (csum_match)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load_err_d;
    end
  end

  assign load_err = load_err_q;
`else
  localparam logic [2:0] LAST_IDX = 3'(IDX_A2);
  assign load_err = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    shadow_d       = shadow_q;
    coef_d         = coef_q;
    coeff_update_d = 1'b0;
`ifdef COEFF_CHECKSUM_EN
    load_err_d     = 1'b0;
`endif
    if (cfg.cfg_abort) begin
      state_d = ST_LOAD;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (accept) begin
            // The checksum word lands on index NUM_COEF and is consumed only by the accumulator.
            for (int i = 0; i < NUM_COEF; i++) begin
              if (idx_q == 3'(i)) shadow_d[i] = cfg.cfg_data;
            end
            if (idx_q == LAST_IDX) begin
              idx_d = '0;
`ifdef COEFF_CHECKSUM_EN
              state_d = ST_CHECK;
`else
              state_d = ST_PEND;
`endif
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
        ST_PEND: begin
          if (sample_tick) begin
            coef_d         = shadow_q;
            coeff_update_d = 1'b1;
            state_d        = ST_LOAD;
          end
        end
`ifdef COEFF_CHECKSUM_EN
        ST_CHECK: begin
          if (csum_match) begin
            state_d = ST_PEND;
          end else begin
            state_d    = ST_LOAD;
            load_err_d = 1'b1;
          end
        end
`endif
        default: state_d = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_LOAD;
      idx_q          <= '0;
      coeff_update_q <= 1'b0;
      for (int i = 0; i < NUM_COEF; i++) begin
        shadow_q[i] <= '0;
        coef_q[i]   <= INIT_VAL[i];
      end
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      coeff_update_q <= coeff_update_d;
      shadow_q       <= shadow_d;
      coef_q         <= coef_d;
    end
  end

  assign b0_out       = coef_q[IDX_B0];
  assign b1_out       = coef_q[IDX_B1];
  assign b2_out       = coef_q[IDX_B2];
  assign a1_out       = coef_q[IDX_A1];
  assign a2_out       = coef_q[IDX_A2];
  assign coeff_update = coeff_update_q;
  assign pending      = (state_q == ST_PEND);

endmodule
